// File: rtl/if_fetch_unit.sv
// Instruction fetch stage (optional STATIC_PRED_EN): owns the PC, keeps one imem request outstanding, feeds IF/ID.
// Latency: pc/inst are presented on the edge that consumes rvalid; with single-cycle gnt and rvalid, one instruction every 2 cycles.
// Backpressure: stall freezes the IF/ID outputs and parks a returning word in a one-entry hold buffer; redirect overrides stall.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        flush,
    output logic        pred_taken
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc, hold_inst;
    logic        hold_pred;
    logic        present_live, present_hold, capture;
    logic [31:0] step;
    logic        pred_hit;

`ifdef STATIC_PRED_EN
    logic [31:0] jal_imm, br_imm;

    // Static prediction: JAL always taken, conditional branches taken only when backward.
    always_comb begin
        jal_imm  = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20], imem_rdata[30:21], 1'b0};
        br_imm   = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0};
        pred_hit = 1'b0;
        step     = 32'd4;
        if (imem_rdata[6:0] == 7'b1101111) begin
            pred_hit = 1'b1;
            step     = jal_imm;
        end else if (imem_rdata[6:0] == 7'b1100011 && imem_rdata[31]) begin
            pred_hit = 1'b1;
            step     = br_imm;
        end
    end
`else
    assign pred_hit = 1'b0;
    assign step     = 32'd4;
`endif

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign flush     = redirect_valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        present_live = 1'b0;
        present_hold = 1'b0;
        capture      = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (imem_gnt) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    pc_d = pc_q + step;
                    if (stall) begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        present_live = 1'b1;
                        state_d      = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    present_hold = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_DRAIN: if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        // A granted-but-unreturned request must be drained before refetching.
        if (redirect_valid) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            present_live = 1'b0;
            present_hold = 1'b0;
            capture      = 1'b0;
            case (state_q)
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                S_REQ:   state_d = imem_gnt ? S_DRAIN : S_REQ;
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pc_out     <= 32'd0;
            inst_out   <= BUBBLE_INST;
            inst_valid <= 1'b0;
            pred_taken <= 1'b0;
            hold_pc    <= 32'd0;
            hold_inst  <= BUBBLE_INST;
            hold_pred  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (redirect_valid || (!stall && !present_live && !present_hold)) begin
                pc_out     <= 32'd0;
                inst_out   <= BUBBLE_INST;
                inst_valid <= 1'b0;
                pred_taken <= 1'b0;
            end else if (present_live) begin
                pc_out     <= pc_q;
                inst_out   <= imem_rdata;
                inst_valid <= 1'b1;
                pred_taken <= pred_hit;
            end else if (present_hold) begin
                pc_out     <= hold_pc;
                inst_out   <= hold_inst;
                inst_valid <= 1'b1;
                pred_taken <= hold_pred;
            end
            if (redirect_valid) begin
                hold_pc   <= 32'd0;
                hold_inst <= BUBBLE_INST;
                hold_pred <= 1'b0;
            end else if (capture) begin
                hold_pc   <= pc_q;
                hold_inst <= imem_rdata;
                hold_pred <= pred_hit;
            end
        end
    end

endmodule
